// File: rtl/ex_div_seq_if.sv
// ----------------------------------------------------------------------------
// ex_div_seq_if
//   Request/response bundle between the EX stage and the divide sequencer.
//   Ports (all inside the interface):
//     div_i_start     EX -> div   divide request, level, held until ready
//     div_i_signed    EX -> div   1 = signed divide, 0 = unsigned
//     div_i_annul     EX -> div   abort current/pending divide
//     div_i_opdata1   EX -> div   dividend
//     div_i_opdata2   EX -> div   divisor
//     div_o_result    div -> EX   {remainder, quotient}, valid while ready=1
//     div_o_ready     div -> EX   result valid
//     div_o_stallreq  div -> EX   stall the EX stage
//   Modports: master = EX stage side, slave = divider side.
// ----------------------------------------------------------------------------
interface ex_div_seq_if #(
    parameter int DATA_W = 32
);
    logic                  div_i_start;
    logic                  div_i_signed;
    logic                  div_i_annul;
    logic [DATA_W-1:0]     div_i_opdata1;
    logic [DATA_W-1:0]     div_i_opdata2;
    logic [2*DATA_W-1:0]   div_o_result;
    logic                  div_o_ready;
    logic                  div_o_stallreq;

    modport master (
        output div_i_start, div_i_signed, div_i_annul, div_i_opdata1, div_i_opdata2,
        input  div_o_result, div_o_ready, div_o_stallreq
    );

    modport slave (
        input  div_i_start, div_i_signed, div_i_annul, div_i_opdata1, div_i_opdata2,
        output div_o_result, div_o_ready, div_o_stallreq
    );
endinterface

// File: rtl/ex_div_seq.sv
// ----------------------------------------------------------------------------
// ex_div_seq
//   Multi-cycle restoring divider for the EX stage, one quotient bit per clock.
//   Operands are converted to magnitudes at start, divided unsigned, and the
//   signs are re-applied on the final step. Result is {remainder, quotient}.
//   Ports:
//     clk    rising-edge clock
//     rst_   asynchronous active-low reset
//     bus    ex_div_seq_if.slave (request, operands, result, ready, stallreq)
// ----------------------------------------------------------------------------
module ex_div_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic            clk,
    input  logic            rst_,
    ex_div_seq_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BYZERO,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_dq;        // dividend shifts out the top, quotient shifts in the bottom
    logic [DATA_W-1:0]     r_divisor;
    logic [DATA_W-1:0]     r_rem;
    logic                  r_qneg;
    logic                  r_rneg;
    logic [2*DATA_W-1:0]   r_result;
    logic                  r_ready;

    logic                  w_req;
    logic                  w_last;
    logic                  w_div_zero;
    logic                  w_sign1;
    logic                  w_sign2;
    logic [DATA_W-1:0]     w_abs1;
    logic [DATA_W-1:0]     w_abs2;
    logic [DATA_W:0]       w_rem_sh;
    logic [DATA_W:0]       w_diff;
    logic                  w_ge;
    logic [DATA_W-1:0]     w_rem_nxt;
    logic [DATA_W-1:0]     w_quo_raw;
    logic [DATA_W-1:0]     w_quo_fix;
    logic [DATA_W-1:0]     w_rem_fix;

    assign w_req      = bus.div_i_start & ~bus.div_i_annul;
    assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_div_zero = (bus.div_i_opdata2 == '0);

    // Magnitudes are only taken for signed requests; the most-negative value
    // maps onto itself, which is exactly its unsigned magnitude.
    assign w_sign1 = bus.div_i_signed & bus.div_i_opdata1[DATA_W-1];
    assign w_sign2 = bus.div_i_signed & bus.div_i_opdata2[DATA_W-1];
    assign w_abs1  = w_sign1 ? (~bus.div_i_opdata1 + 1'b1) : bus.div_i_opdata1;
    assign w_abs2  = w_sign2 ? (~bus.div_i_opdata2 + 1'b1) : bus.div_i_opdata2;

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value is below 2*divisor and bit DATA_W of the
    // difference is a clean borrow (1 = shifted value < divisor).
    assign w_rem_sh  = {r_rem, r_dq[DATA_W-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_divisor};
    assign w_ge      = ~w_diff[DATA_W];
    assign w_rem_nxt = w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];

    assign w_quo_raw = {r_dq[DATA_W-2:0], w_ge};
    assign w_quo_fix = r_qneg ? (~w_quo_raw + 1'b1) : w_quo_raw;
    assign w_rem_fix = r_rneg ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

    assign bus.div_o_result   = r_result;
    assign bus.div_o_ready    = r_ready;
    assign bus.div_o_stallreq = w_req & (r_state != S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the next-state default is assigned first so no path through the
    // case leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = w_div_zero ? S_BYZERO : S_BUSY;
                end
            end
            S_BYZERO: begin
                w_state_nxt = bus.div_i_annul ? S_IDLE : S_DONE;
            end
            S_BUSY: begin
                if (bus.div_i_annul) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!w_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the operand/remainder registers are reset too even though they are
    // reloaded before use; it keeps simulation free of X and costs nothing here.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cnt     <= '0;
            r_dq      <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && !w_div_zero) begin
                        r_dq      <= w_abs1;
                        r_divisor <= w_abs2;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_qneg    <= w_sign1 ^ w_sign2;
                        r_rneg    <= w_sign1;
                    end
                end
                S_BYZERO: begin
                    if (!bus.div_i_annul) begin
                        r_result <= '0;
                        r_ready  <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (!bus.div_i_annul) begin
                        r_dq  <= w_quo_raw;
                        r_rem <= w_rem_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                            r_ready  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!w_req) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_seq.sv
// ----------------------------------------------------------------------------
// tb_ex_div_seq
//   Directed and randomized checks of ex_div_seq against an arithmetic
//   reference model (SV / and % with explicit divide-by-zero and overflow cases).
// ----------------------------------------------------------------------------
module tb_ex_div_seq;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    logic clk;
    logic rst_;
    int   n_cmp;
    int   n_bad;

    ex_div_seq_if #(.DATA_W(DATA_W)) bus ();

    ex_div_seq #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Full transaction: request, wait for ready (bounded), check latency,
    // stall behaviour, result, hold in DONE, and release back to IDLE.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp);
        int edges;
        int exp_lat;
        bit stall_ok;
        exp_lat = (b == 32'd0) ? 2 : DATA_W + 1;
        bus.div_i_opdata1 = a;
        bus.div_i_opdata2 = b;
        bus.div_i_signed  = s;
        bus.div_i_annul   = 1'b0;
        bus.div_i_start   = 1'b1;
        #1;
        edges    = 0;
        stall_ok = 1'b1;
        while (bus.div_o_ready !== 1'b1 && edges < 40) begin
            if (bus.div_o_stallreq !== 1'b1) stall_ok = 1'b0;
            tick();
            if (edges == 0) begin
                // Operands are ignored once the request has been accepted.
                bus.div_i_opdata1 = $urandom;
                bus.div_i_opdata2 = $urandom;
                bus.div_i_signed  = ~s;
            end
            edges++;
        end
        check({tag, "/latency"}, 64'(edges), 64'(exp_lat));
        check({tag, "/stall_while_busy"}, 64'(stall_ok), 64'd1);
        check({tag, "/result"}, bus.div_o_result, exp);
        check({tag, "/stall_in_done"}, 64'(bus.div_o_stallreq), 64'd0);
        tick();
        check({tag, "/hold_ready"}, 64'(bus.div_o_ready), 64'd1);
        check({tag, "/hold_result"}, bus.div_o_result, exp);
        bus.div_i_start = 1'b0;
        tick();
        check({tag, "/release_ready"}, 64'(bus.div_o_ready), 64'd0);
        check({tag, "/release_result"}, bus.div_o_result, 64'd0);
    endtask

    initial begin
        int ready_seen;
        int waited;
        logic [31:0] a;
        logic [31:0] b;
        logic s;

        n_cmp = 0;
        n_bad = 0;
        rst_              = 1'b0;
        bus.div_i_start   = 1'b0;
        bus.div_i_signed  = 1'b0;
        bus.div_i_annul   = 1'b0;
        bus.div_i_opdata1 = '0;
        bus.div_i_opdata2 = '0;

        #3;
        check("reset/ready", 64'(bus.div_o_ready), 64'd0);
        check("reset/result", bus.div_o_result, 64'd0);
        check("reset/stall", 64'(bus.div_o_stallreq), 64'd0);
        #9 rst_ = 1'b1;
        tick();

        // Directed cases
        do_div("udiv_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
        do_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD});
        do_div("divzero", 32'h1234, 32'd0, 1'b0, 64'd0);
        do_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000});

        // Annul at step 10 of 100/7
        bus.div_i_opdata1 = 32'd100;
        bus.div_i_opdata2 = 32'd7;
        bus.div_i_signed  = 1'b0;
        bus.div_i_start   = 1'b1;
        tick();
        repeat (10) tick();
        bus.div_i_annul = 1'b1;
        #1;
        check("annul/stall", 64'(bus.div_o_stallreq), 64'd0);
        tick();
        bus.div_i_start = 1'b0;
        bus.div_i_annul = 1'b0;
        ready_seen = 0;
        repeat (40) begin
            tick();
            if (bus.div_o_ready === 1'b1) ready_seen++;
        end
        check("annul/ready_never", 64'(ready_seen), 64'd0);
        check("annul/result_zero", bus.div_o_result, 64'd0);
        do_div("after_annul_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

        // Annul in BYZERO returns to IDLE without ready
        bus.div_i_opdata1 = 32'd5;
        bus.div_i_opdata2 = 32'd0;
        bus.div_i_start   = 1'b1;
        tick();
        bus.div_i_annul = 1'b1;
        tick();
        check("byzero_annul/ready", 64'(bus.div_o_ready), 64'd0);
        bus.div_i_start = 1'b0;
        bus.div_i_annul = 1'b0;
        tick();
        check("byzero_annul/ready2", 64'(bus.div_o_ready), 64'd0);

        // start together with annul in IDLE is ignored (divide by zero would
        // otherwise raise ready within two edges)
        bus.div_i_start = 1'b1;
        bus.div_i_annul = 1'b1;
        repeat (3) tick();
        check("start_annul/ready", 64'(bus.div_o_ready), 64'd0);
        check("start_annul/stall", 64'(bus.div_o_stallreq), 64'd0);
        bus.div_i_start = 1'b0;
        bus.div_i_annul = 1'b0;
        tick();

        // Asynchronous reset mid-BUSY
        bus.div_i_opdata1 = 32'd100;
        bus.div_i_opdata2 = 32'd7;
        bus.div_i_start   = 1'b1;
        tick();
        repeat (5) tick();
        #2 rst_ = 1'b0;
        #1;
        check("rst_busy/ready", 64'(bus.div_o_ready), 64'd0);
        check("rst_busy/result", bus.div_o_result, 64'd0);
        bus.div_i_start = 1'b0;
        #1 rst_ = 1'b1;
        tick();
        do_div("after_rst_1000_33", 32'd1000, 32'd33, 1'b0, {32'd10, 32'd30});

        // Asynchronous reset while holding a result in DONE
        bus.div_i_opdata1 = 32'd12345;
        bus.div_i_opdata2 = 32'd10;
        bus.div_i_start   = 1'b1;
        waited = 0;
        while (bus.div_o_ready !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        check("rst_done/ready_before", 64'(bus.div_o_ready), 64'd1);
        check("rst_done/result_before", bus.div_o_result, {32'd5, 32'd1234});
        #2 rst_ = 1'b0;
        #1;
        check("rst_done/ready", 64'(bus.div_o_ready), 64'd0);
        check("rst_done/result", bus.div_o_result, 64'd0);
        bus.div_i_start = 1'b0;
        #1 rst_ = 1'b1;
        tick();

        // Randomized divisions against the reference model
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       b = 32'($urandom_range(1, 15));
                1:       b = ~32'($urandom_range(0, 14));
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'd0;
                default: b = $urandom;
            endcase
            do_div($sformatf("rand%0d", i), a, b, s, ref_div(a, b, s));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
